fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the byte-addressed instruction memory. Holds the program counter, drives the combinational memory address, and captures each returned 32-bit big-endian instruction word with its PC into a registered valid/ready output slot for decode. Handles branch/jump redirects, back-pressure, an all-zero halt word, and misaligned or out-of-range fetches.

## Interface
- RESET_PC, 64'h0, PC loaded on reset
- MEM_SIZE, 4095, instruction memory size in bytes (must match memory instance)
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- imem_addr  output  64  byte address to instruction memory; equals PC register
- imem_instr  input  32  instruction word from memory, combinational from imem_addr
- redirect_valid  input  1  load redirect_pc this cycle (branch/jump taken)
- redirect_pc  input  64  redirect target
- out_valid  output  1  out_pc/out_instr hold a fetched instruction
- out_ready  input  1  decode accepts the output slot this cycle
- out_pc  output  64  PC of out_instr
- out_instr  output  32  fetched instruction
- halted  output  1  state == HALT
- fault  output  1  state == FAULT
- fetch_count  output  32  instructions delivered (out_valid & out_ready), wraps at 2^32

## Operation
- States: RUN, HALT, FAULT. Reset -> RUN.
- In range: pc[1:0]==0 and pc+3 <= MEM_SIZE-1 (full 64-bit compare, no truncation).
- slot_free = !out_valid | out_ready.
- RUN, no redirect, slot_free, pc in range, imem_instr != 0: out_pc<=pc, out_instr<=imem_instr, out_valid<=1, pc<=pc+4.
- RUN, slot_free, imem_instr == 32'h0: -> HALT; word not emitted; pc holds; out_valid<=0 once current slot accepted.
- RUN, pc out of range or misaligned: -> FAULT, out_valid<=0, pc holds (fault PC visible on imem_addr).
- !slot_free: out regs and pc hold; no fetch.
- redirect_valid (RUN or HALT): highest priority over stall and halt; out_valid<=0 (slot flushed, even if out_ready high that cycle — no delivery, fetch_count not incremented); pc<=redirect_pc; state -> RUN. Alignment/range of new pc checked next cycle.
- FAULT: absorbing; redirect ignored; only reset exits.
- fetch_count increments on out_valid & out_ready & !redirect_valid.

## Timing
- Reset values: pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0, fetch_count=0, halted=0, fault=0.
- Fetch latency: 1 cycle, PC on imem_addr at cycle N -> out_valid with that PC after edge N.
- Throughput: 1 instr/cycle with out_ready held high.
- Redirect penalty: 1 bubble; target instruction valid 1 cycle after redirect edge.
- out_pc/out_instr stable while out_valid & !out_ready.
- Reset deassertion mid-stream: first fetch from RESET_PC on first rising edge after release.

## Structure
- Shared package fetch_pkg: state enum (RUN/HALT/FAULT), HALT_WORD = 32'h0, INSTR_BYTES = 4.
- Single module; no sub-module needed. Top-level wiring connects imem_addr/imem_instr to instruction_memory addr/instr.

## Test plan
- Straight line: memory words 0x00500093, 0x00A00113, 0x0 at 0/4/8, out_ready=1 -> out_pc 0,4 on consecutive cycles, halted=1 after, fetch_count=2.
- Back-pressure: out_ready low 3 cycles with out_valid=1 at pc 4 -> out_pc/out_instr unchanged, imem_addr=8 held, no lost or duplicated instruction.
- Redirect: redirect_valid with redirect_pc=0x40 while out_ready=0 -> out_valid=0 next cycle, out_pc=0x40 cycle after; flushed word not counted.
- Faults: redirect_pc=0x42 -> fault=1 next cycle, later redirect ignored; separately pc reaching MEM_SIZE-3 -> fault=1, imem_addr holds.
- Halt resume: in HALT, redirect_pc=0x10 -> RUN, halted=0, fetch resumes at 0x10.
- Async reset mid-stream: reset=0 between edges -> outputs at reset values immediately; refetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Pure declarations: no latency, no flow control.
// State encoding is visible to anything that wants to decode halted/fault.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] HALT_WORD   = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register drives imem_addr, returned word lands in a registered output slot.
// Latency 1 cycle from PC on imem_addr to out_valid; redirect costs one bubble.
// Slot holds (pc and outputs frozen) while out_valid & !out_ready; redirect flushes the slot.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] MEM_SIZE = 64'd4095
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         out_valid_q, out_valid_d;
    logic [63:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_instr_q, out_instr_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    logic         slot_free;
    logic         in_range;
    logic [64:0]  last_byte;

    // One extra bit so a PC near 2^64 cannot wrap into the valid window.
    assign last_byte = {1'b0, pc_q} + 65'd3;
    assign in_range  = (pc_q[1:0] == 2'b00) && (last_byte <= ({1'b0, MEM_SIZE} - 65'd1));
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        fetch_count_d = fetch_count_q;

        if (out_valid_q && out_ready && !redirect_valid) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        case (state_q)
            ST_RUN, ST_HALT: begin
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    pc_d        = redirect_pc;
                    state_d     = ST_RUN;
                end else if (slot_free) begin
                    out_valid_d = 1'b0;
                    if (state_q == ST_RUN) begin
                        // Range is checked before the halt word: out-of-range reads are undefined.
                        if (!in_range) begin
                            state_d = ST_FAULT;
                        end else if (imem_instr == HALT_WORD) begin
                            state_d = ST_HALT;
                        end else begin
                            out_valid_d = 1'b1;
                            out_pc_d    = pc_q;
                            out_instr_d = imem_instr;
                            pc_d        = pc_q + 64'(INSTR_BYTES);
                        end
                    end
                end
            end
            ST_FAULT: begin
                out_valid_d = 1'b0;
            end
            default: begin
                state_d     = ST_FAULT;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 64'h0;
            out_instr_q   <= 32'h0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_instr   = out_instr_q;
    assign halted      = (state_q == ST_HALT);
    assign fault       = (state_q == ST_FAULT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: byte-array big-endian memory model, scoreboard of expected deliveries.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int total;
    int bad;

    logic [7:0]  mem [0:4095];
    logic [95:0] exp_q[$];
    logic [95:0] got_q[$];

    fetch_unit #(.RESET_PC(64'h0), .MEM_SIZE(64'd4095)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        int a;
        a = int'(imem_addr[11:0]);
        imem_instr = 32'hFFFF_FFFF;
        if (imem_addr <= 64'd4092) begin
            imem_instr = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
        end
    end

    // Record every accepted delivery: slot valid, decode ready, not flushed.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready && !redirect_valid) begin
            got_q.push_back({out_pc, out_instr});
        end
    end

    task automatic put_word(input int addr, input logic [31:0] w);
        mem[addr]   = w[31:24];
        mem[addr+1] = w[23:16];
        mem[addr+2] = w[15:8];
        mem[addr+3] = w[7:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        logic [95:0] g;
        logic [95:0] e;
        while (got_q.size() != 0 || exp_q.size() != 0) begin
            total++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s_sb: delivered_left=%0d expected_left=%0d", name, got_q.size(), exp_q.size());
                got_q.delete();
                exp_q.delete();
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL %s_sb: got pc=%h instr=%h want pc=%h instr=%h", name, g[95:32], g[31:0], e[95:32], e[31:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if ({out_valid, halted, fault} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {out_valid, halted, fault});
        end
        total++;
        if (imem_addr !== 64'h0 || out_pc !== 64'h0 || out_instr !== 32'h0 || fetch_count !== 32'h0) begin
            bad++; $display("FAIL reset_regs: addr=%h pc=%h instr=%h cnt=%0d want all 0", imem_addr, out_pc, out_instr, fetch_count);
        end
    endtask

    task automatic test_straight();
        out_ready = 1'b1;
        exp_q.push_back({64'h0, 32'h0050_0093});
        exp_q.push_back({64'h4, 32'h00A0_0113});
        @(negedge clk);
        reset = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h0050_0093) begin
            bad++; $display("FAIL straight_first: v=%b pc=%h instr=%h want 1 0 00500093", out_valid, out_pc, out_instr);
        end
        step();
        total++;
        if (out_pc !== 64'h4) begin
            bad++; $display("FAIL straight_second: pc=%h want 4", out_pc);
        end
        step();
        total++;
        if (halted !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 32'd2 || imem_addr !== 64'h8) begin
            bad++; $display("FAIL straight_halt: h=%b v=%b cnt=%0d addr=%h want 1 0 2 8", halted, out_valid, fetch_count, imem_addr);
        end
        drain("straight");
    endtask

    task automatic test_backpressure();
        exp_q.push_back({64'h0, 32'h0050_0093});
        exp_q.push_back({64'h4, 32'h00A0_0113});
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        step();
        redirect_valid = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 64'h4 || out_instr !== 32'h00A0_0113 || imem_addr !== 64'h8) begin
                bad++; $display("FAIL bp_hold%0d: v=%b pc=%h instr=%h addr=%h want 1 4 00a00113 8", i, out_valid, out_pc, out_instr, imem_addr);
            end
        end
        out_ready = 1'b1;
        step();
        total++;
        if (halted !== 1'b1 || fetch_count !== 32'd4) begin
            bad++; $display("FAIL bp_end: h=%b cnt=%0d want 1 4", halted, fetch_count);
        end
        drain("bp");
    endtask

    task automatic test_redirect();
        exp_q.push_back({64'h40, 32'h4040_4040});
        exp_q.push_back({64'h44, 32'h4444_4444});
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h10;
        step();
        total++;
        if (halted !== 1'b0 || imem_addr !== 64'h10 || out_valid !== 1'b0) begin
            bad++; $display("FAIL resume: h=%b addr=%h v=%b want 0 10 0", halted, imem_addr, out_valid);
        end
        redirect_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 64'h10) begin
            bad++; $display("FAIL resume_fetch: v=%b pc=%h want 1 10", out_valid, out_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        step();
        total++;
        if (out_valid !== 1'b0 || imem_addr !== 64'h40 || fetch_count !== 32'd4) begin
            bad++; $display("FAIL redir_flush: v=%b addr=%h cnt=%0d want 0 40 4", out_valid, imem_addr, fetch_count);
        end
        redirect_valid = 1'b0; out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== 32'h4040_4040) begin
            bad++; $display("FAIL redir_target: v=%b pc=%h instr=%h want 1 40 40404040", out_valid, out_pc, out_instr);
        end
        step();
        step();
        total++;
        if (halted !== 1'b1 || fetch_count !== 32'd6) begin
            bad++; $display("FAIL redir_end: h=%b cnt=%0d want 1 6", halted, fetch_count);
        end
        drain("redir");
    endtask

    task automatic test_flush_ready_high();
        exp_q.push_back({64'h10, 32'h1111_1111});
        exp_q.push_back({64'h14, 32'h2222_2222});
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 64'h10;
        step();
        total++;
        if (out_valid !== 1'b0 || fetch_count !== 32'd6) begin
            bad++; $display("FAIL flush_hi: v=%b cnt=%0d want 0 6", out_valid, fetch_count);
        end
        redirect_valid = 1'b0;
        step(); step(); step();
        total++;
        if (halted !== 1'b1 || fetch_count !== 32'd8 || imem_addr !== 64'h18) begin
            bad++; $display("FAIL flush_end: h=%b cnt=%0d addr=%h want 1 8 18", halted, fetch_count, imem_addr);
        end
        drain("flush");
    endtask

    task automatic test_fault_misaligned();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h42;
        step();
        redirect_valid = 1'b0;
        total++;
        if (fault !== 1'b0 || halted !== 1'b0) begin
            bad++; $display("FAIL mis_pre: f=%b h=%b want 0 0", fault, halted);
        end
        step();
        total++;
        if (fault !== 1'b1 || imem_addr !== 64'h42 || out_valid !== 1'b0) begin
            bad++; $display("FAIL mis_fault: f=%b addr=%h v=%b want 1 42 0", fault, imem_addr, out_valid);
        end
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        step();
        redirect_valid = 1'b0;
        total++;
        if (fault !== 1'b1 || imem_addr !== 64'h42) begin
            bad++; $display("FAIL mis_absorb: f=%b addr=%h want 1 42", fault, imem_addr);
        end
        drain("mis");
    endtask

    task automatic test_async_reset();
        exp_q.push_back({64'h0, 32'h0050_0093});
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (fault !== 1'b0 || imem_addr !== 64'h0 || fetch_count !== 32'd0) begin
            bad++; $display("FAIL arst_fault: f=%b addr=%h cnt=%0d want 0 0 0", fault, imem_addr, fetch_count);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0 || imem_addr !== 64'h0 || fetch_count !== 32'd0) begin
            bad++; $display("FAIL arst_mid: v=%b pc=%h instr=%h addr=%h cnt=%0d want 0 0 0 0 0", out_valid, out_pc, out_instr, imem_addr, fetch_count);
        end
        drain("arst_a");
        exp_q.push_back({64'h0, 32'h0050_0093});
        exp_q.push_back({64'h4, 32'h00A0_0113});
        #1;
        reset = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
            bad++; $display("FAIL arst_refetch: v=%b pc=%h want 1 0", out_valid, out_pc);
        end
        step(); step();
        total++;
        if (halted !== 1'b1 || fetch_count !== 32'd2) begin
            bad++; $display("FAIL arst_end: h=%b cnt=%0d want 1 2", halted, fetch_count);
        end
        drain("arst_b");
    endtask

    task automatic test_fault_range();
        exp_q.push_back({64'hFF0, 32'hAAAA_0001});
        exp_q.push_back({64'hFF4, 32'hAAAA_0002});
        exp_q.push_back({64'hFF8, 32'hAAAA_0003});
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'hFF0;
        step();
        redirect_valid = 1'b0;
        step(); step(); step();
        total++;
        if (fault !== 1'b0 || imem_addr !== 64'hFFC) begin
            bad++; $display("FAIL range_pre: f=%b addr=%h want 0 ffc", fault, imem_addr);
        end
        step();
        total++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 32'd5) begin
            bad++; $display("FAIL range_fault: f=%b v=%b cnt=%0d want 1 0 5", fault, out_valid, fetch_count);
        end
        step();
        total++;
        if (imem_addr !== 64'hFFC || fault !== 1'b1) begin
            bad++; $display("FAIL range_hold: addr=%h f=%b want ffc 1", imem_addr, fault);
        end
        drain("range");
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        out_ready = 1'b0;
        total = 0;
        bad = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        put_word(32'h000, 32'h0050_0093);
        put_word(32'h004, 32'h00A0_0113);
        put_word(32'h010, 32'h1111_1111);
        put_word(32'h014, 32'h2222_2222);
        put_word(32'h040, 32'h4040_4040);
        put_word(32'h044, 32'h4444_4444);
        put_word(32'hFF0, 32'hAAAA_0001);
        put_word(32'hFF4, 32'hAAAA_0002);
        put_word(32'hFF8, 32'hAAAA_0003);
        put_word(32'hFFC, 32'hBBBB_0004);
        #2;
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect();
        test_flush_ready_high();
        test_fault_misaligned();
        test_async_reset();
        test_fault_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
